// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, one serial bit per clk cycle.
// Frame = start bit (0), DATA_SIZE data bits LSB first, optional parity, stop bit (1).
// Outputs come straight from flops, so the line never glitches.
//
// Handshake: data_valid is a request that is only sampled while idle. The
// word and the parity controls are captured on the accepting edge. Requests
// made while busy is high are dropped, not queued.
module uart_tx #(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] p_data,
    input  logic                 data_valid,
    input  logic                 par_en,
    input  logic                 par_typ,
    output logic                 tx_out,
    output logic                 busy
);

    localparam int CW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   shift_q, shift_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;

    // State register; reset forces IDLE and overrides any request on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the frame walks START -> DATA x N -> [PARITY] -> STOP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (data_valid) state_d = S_START;
            S_START:  state_d = S_DATA;
            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values. The line value is computed for the state
    // being entered, so the registered tx/busy line up with the registered state.
    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = 1'b1;
        busy_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_valid) begin
                    shift_d   = p_data;
                    par_en_d  = par_en;
                    par_bit_d = (^p_data) ^ par_typ;
                end
            end
            S_START: begin
                // bit 0 goes onto the line at this edge; expose the next bit
                cnt_d   = '0;
                shift_d = shift_q >> 1;
            end
            S_DATA: begin
                shift_d = shift_q >> 1;
                if (cnt_q != LAST_BIT) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase

        case (state_d)
            S_START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            S_DATA: begin
                tx_d   = shift_q[0];
                busy_d = 1'b1;
            end
            S_PARITY: begin
                tx_d   = par_bit_q;
                busy_d = 1'b1;
            end
            S_STOP: begin
                tx_d   = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output flops; reset aborts any frame and returns the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule
